// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit maximum and clamp helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Non-decimal nibbles (A-F) are forced to the largest legal digit.
   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_downcount_if.sv
// bcd_downcount_if: control and count bus of the BCD down counter.
// Latency: n/a (wires only).
// Backpressure: none; the counter accepts a control word every cycle.
// Signals: EN, LOAD, LOAD_VAL (master -> counter); COUNT, ZERO, BORROW (counter -> master).
interface bcd_downcount_if #(
   parameter int DIGITS = 2
);
   logic                  EN;
   logic                  LOAD;
   logic [4*DIGITS-1:0]   LOAD_VAL;
   logic [4*DIGITS-1:0]   COUNT;
   logic                  ZERO;
   logic                  BORROW;

   modport master (
      output EN,
      output LOAD,
      output LOAD_VAL,
      input  COUNT,
      input  ZERO,
      input  BORROW
   );

   modport slave (
      input  EN,
      input  LOAD,
      input  LOAD_VAL,
      output COUNT,
      output ZERO,
      output BORROW
   );
endinterface

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one registered BCD digit with load, wrap override and borrow chain.
// Latency: one cycle from load/borrow-in to digit_o; borrow_o is combinational.
// Backpressure: none.
// Ports: clk_i, rst_n_i, load_i, load_dig_i (pre-clamped), borrow_i, wrap_i, wrap_val_i,
//        borrow_o, digit_o, is_zero_o.
module bcd_digit_down
   import bcd_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       load_i,
   input  bcd_digit_t load_dig_i,
   input  logic       borrow_i,
   input  logic       wrap_i,
   input  bcd_digit_t wrap_val_i,
   output logic       borrow_o,
   output bcd_digit_t digit_o,
   output logic       is_zero_o
);

   bcd_digit_t digit_q;
   bcd_digit_t digit_d;

   assign is_zero_o = (digit_q == 4'd0);
   // A zero digit cannot absorb the borrow, so it passes it upward.
   assign borrow_o  = borrow_i & is_zero_o;
   assign digit_o   = digit_q;

   always_comb begin
      digit_d = digit_q;
      if (load_i) begin
         digit_d = load_dig_i;
      end else if (wrap_i) begin
         // Wrap overrides the plain 0 -> 9 borrow so the reload value can land.
         digit_d = wrap_val_i;
      end else if (borrow_i) begin
         digit_d = is_zero_o ? BCD_MAX : (digit_q - 4'd1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

endmodule

// File: rtl/bcd_downcount.sv
// bcd_downcount: multi-digit BCD down counter with load, enable, zero flag and borrow pulse.
// Latency: one cycle from LOAD/EN to COUNT and BORROW; ZERO is decoded from COUNT (no extra cycle).
// Backpressure: none; one decrement per enabled clock, LOAD has priority over EN.
// Ports: CLK, RESET_N (async active-low), bus (bcd_downcount_if.slave).
// Option: BCD_DOWNCOUNT_AUTORELOAD_EN makes the wrap value the last clamped load value
//         instead of all nines.
module bcd_downcount
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic           CLK,
   input  logic           RESET_N,
   bcd_downcount_if.slave bus
);

   logic [4*DIGITS-1:0] load_clamped;
   logic [4*DIGITS-1:0] wrap_val;
   logic [4*DIGITS-1:0] count_w;
   logic [DIGITS-1:0]   dig_zero;
   logic [DIGITS:0]     borrow_chain;
   logic                wrap_evt;
   logic                borrow_q;
   logic                borrow_d;

   // The decrement request enters at digit 0; a load suppresses it.
   assign borrow_chain[0] = bus.EN & ~bus.LOAD;

   // A borrow escaping the top digit means every digit was zero while
   // enabled: exactly the wrap condition.
   assign wrap_evt = borrow_chain[DIGITS];

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign load_clamped[4*gi +: 4] = bcd_clamp(bus.LOAD_VAL[4*gi +: 4]);

         bcd_digit_down u_digit (
            .clk_i      (CLK),
            .rst_n_i    (RESET_N),
            .load_i     (bus.LOAD),
            .load_dig_i (load_clamped[4*gi +: 4]),
            .borrow_i   (borrow_chain[gi]),
            .wrap_i     (wrap_evt),
            .wrap_val_i (wrap_val[4*gi +: 4]),
            .borrow_o   (borrow_chain[gi+1]),
            .digit_o    (count_w[4*gi +: 4]),
            .is_zero_o  (dig_zero[gi])
         );
      end
   endgenerate

`ifdef BCD_DOWNCOUNT_AUTORELOAD_EN
   logic [4*DIGITS-1:0] reload_q;
   logic [4*DIGITS-1:0] reload_d;

   always_comb begin
      reload_d = reload_q;
      if (bus.LOAD) begin
         reload_d = load_clamped;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         reload_q <= '0;
      end else begin
         reload_q <= reload_d;
      end
   end

   // A zero reload value keeps the counter parked at 0, pulsing BORROW.
   assign wrap_val = reload_q;
`else
   assign wrap_val = {DIGITS{BCD_MAX}};
`endif

   assign borrow_d = wrap_evt;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         borrow_q <= 1'b0;
      end else begin
         borrow_q <= borrow_d;
      end
   end

   assign bus.COUNT  = count_w;
   assign bus.ZERO   = &dig_zero;
   assign bus.BORROW = borrow_q;

endmodule

// File: tb/tb_bcd_downcount.sv
// tb_bcd_downcount: scoreboard bench for bcd_downcount (DIGITS = 2).
// Stimulus pushes the expected COUNT/ZERO/BORROW from an integer model into a
// queue; a monitor pops and compares one entry after each rising edge.
module tb_bcd_downcount;

   localparam int D    = 2;
   localparam int MAXV = (10 ** D) - 1;

   typedef struct {
      logic [4*D-1:0] cnt;
      logic           z;
      logic           b;
   } exp_t;

   logic clk;
   logic rst_n;

   bcd_downcount_if #(.DIGITS(D)) bus ();

   bcd_downcount #(.DIGITS(D)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   exp_t q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   errors  = 0;
   int   count_m = 0;
   int   reload_m = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [4*D-1:0] to_bcd(input int n);
      logic [4*D-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'((n / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int clamp_val(input logic [4*D-1:0] v);
      int s;
      int p;
      int nib;
      s = 0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         nib = int'(v[4*i +: 4]);
         if (nib > 9) nib = 9;
         s = s + nib * p;
         p = p * 10;
      end
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every rising edge out of reset presents one output sample.
   always @(posedge clk) begin
      #1;
      if (rst_n && q.size() > 0) begin
         mon_e = q.pop_front();
         chk("count",  32'(bus.COUNT),  32'(mon_e.cnt));
         chk("zero",   32'(bus.ZERO),   32'(mon_e.z));
         chk("borrow", 32'(bus.BORROW), 32'(mon_e.b));
      end
   end

   // One clock of stimulus: drive at negedge, predict, push, wait next negedge.
   task automatic cycle(input logic l, input logic e, input logic [4*D-1:0] v);
      exp_t ex;
      int   wrap;
      bus.LOAD     = l;
      bus.EN       = e;
      bus.LOAD_VAL = v;
`ifdef BCD_DOWNCOUNT_AUTORELOAD_EN
      wrap = reload_m;
`else
      wrap = MAXV;
`endif
      ex.b = 1'b0;
      if (l) begin
         count_m  = clamp_val(v);
         reload_m = count_m;
      end else if (e) begin
         if (count_m == 0) begin
            count_m = wrap;
            ex.b    = 1'b1;
         end else begin
            count_m = count_m - 1;
         end
      end
      ex.cnt = to_bcd(count_m);
      ex.z   = (count_m == 0);
      q.push_back(ex);
      @(negedge clk);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.EN       = 1'b0;
      bus.LOAD     = 1'b0;
      bus.LOAD_VAL = '0;

      // Reset held while EN toggles.
      repeat (4) begin
         @(negedge clk);
         bus.EN = ~bus.EN;
      end
      chk("rst_count",  32'(bus.COUNT),  32'h0);
      chk("rst_zero",   32'(bus.ZERO),   32'h1);
      chk("rst_borrow", 32'(bus.BORROW), 32'h0);

      // Release and count straight away: first edge wraps.
      rst_n = 1'b1;
      cycle(1'b0, 1'b1, 8'h00);

      // Load and decrement through the 20 -> 19 borrow.
      cycle(1'b1, 1'b0, 8'h21);
      repeat (3) cycle(1'b0, 1'b1, 8'h00);

      // Clamp of a non-decimal digit.
      cycle(1'b1, 1'b0, 8'hA3);
      cycle(1'b1, 1'b0, 8'hFF);
      cycle(1'b0, 1'b0, 8'h00);

      // Load beats enable, then plain decrement.
      cycle(1'b1, 1'b1, 8'h50);
      cycle(1'b0, 1'b1, 8'h00);

      // Wrap from 01.
      cycle(1'b1, 1'b0, 8'h01);
      repeat (3) cycle(1'b0, 1'b1, 8'h00);

      // Full lap under sustained enable.
      cycle(1'b1, 1'b0, 8'h99);
      repeat (10 ** D + 2) cycle(1'b0, 1'b1, 8'h00);

      // Mid-count asynchronous reset.
      cycle(1'b1, 1'b0, 8'h37);
      repeat (2) cycle(1'b0, 1'b1, 8'h00);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_count",  32'(bus.COUNT),  32'h0);
      chk("async_rst_zero",   32'(bus.ZERO),   32'h1);
      chk("async_rst_borrow", 32'(bus.BORROW), 32'h0);
      count_m  = 0;
      reload_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h00);

      // Randomised traffic, including A-F nibbles on load.
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
               8'($urandom()));
      end

      bus.EN   = 1'b0;
      bus.LOAD = 1'b0;
      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
